// File: rtl/pc_fetch_pkg.sv
`timescale 1ns/1ps
// Shared types and defaults for the instruction-fetch sequencer and the IF/ID register.
package pc_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    KILL  = 3'd4,
    REDIR = 3'd5
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_pkt_t;

endpackage

// File: rtl/pc_fetch_ctrl.sv
`timescale 1ns/1ps
// Instruction-fetch sequencer: one outstanding read at a time, PC/pipeline stall
// generation, IF/ID buffer ownership and redirect sequencing with response discard.
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR   = NOP_INSTR_DEFAULT,
  parameter int unsigned BOOT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  input  logic        hazard_hold,
  input  logic        dmem_busy,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        pc_stall,
  output logic        next_pc_sel,
  output logic [31:0] redir_tgt,
  output logic        cpu_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam logic [3:0] BOOT_INIT = 4'(BOOT_CYCLES);

  fetch_state_e state_q, state_d;
  logic [3:0]   boot_cnt_q, boot_cnt_d;
  logic         req_q;
  logic         fresh_q;
  logic [31:0]  addr_q;
  logic         redir_pend_q;
  logic [31:0]  redir_tgt_q;
  logic [31:0]  hold_instr_q;
  logic [31:0]  hold_pc_q;
  if_pkt_t      if_q;

  logic         have_instr;
  logic         redir_any;
  logic         deliver;
  logic         in_redir;
  logic [31:0]  fetch_data;
  logic [31:0]  fetch_pc;

  // Instruction availability, delivery qualification and the stall outputs.
  always_comb begin
    have_instr  = ((state_q == WAIT) && imem_rvalid) || (state_q == HOLD);
    redir_any   = redirect || redir_pend_q;
    deliver     = have_instr && !dmem_busy && !hazard_hold && !redir_any;
    in_redir    = (state_q == REDIR);
    fetch_data  = (state_q == HOLD) ? hold_instr_q : imem_rdata;
    fetch_pc    = (state_q == HOLD) ? hold_pc_q : addr_q;
    pc_stall    = !(deliver || in_redir);
    next_pc_sel = in_redir;
    cpu_stall   = in_redir ? dmem_busy : (dmem_busy || !have_instr);
  end

  // Next-state selection; redirects divert the sequence towards KILL or REDIR.
  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    case (state_q)
      BOOT: begin
        if (boot_cnt_q == 4'd0) state_d = REQ;
        else                    boot_cnt_d = boot_cnt_q - 4'd1;
      end
      REQ: begin
        if (imem_gnt) state_d = redir_any ? KILL : WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (redir_any)    state_d = REDIR;
          else if (deliver) state_d = REQ;
          else              state_d = HOLD;
        end else if (redirect) begin
          state_d = KILL;
        end
      end
      HOLD: begin
        if (redir_any)    state_d = REDIR;
        else if (deliver) state_d = REQ;
      end
      KILL: begin
        if (imem_rvalid) state_d = REDIR;
      end
      REDIR:   state_d = REQ;
      default: state_d = BOOT;
    endcase
  end

  // All sequencer state, the request port, the HOLD buffer and the IF/ID register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BOOT;
      boot_cnt_q   <= BOOT_INIT;
      req_q        <= 1'b0;
      fresh_q      <= 1'b0;
      addr_q       <= RESET_PC;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= RESET_PC;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= RESET_PC;
      if_q.valid   <= 1'b0;
      if_q.instr   <= NOP_INSTR;
      if_q.pc      <= RESET_PC;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      req_q      <= (state_d == REQ);
      fresh_q    <= (state_d == REQ) && (state_q != REQ);

      if ((state_q == REQ) && fresh_q) addr_q <= pc_cur;

      if ((state_q != BOOT) && redirect) begin
        redir_tgt_q  <= redirect_pc;
        redir_pend_q <= 1'b1;
      end else if (in_redir) begin
        redir_pend_q <= 1'b0;
      end

      if ((state_q == WAIT) && imem_rvalid && !redir_any && !deliver) begin
        hold_instr_q <= imem_rdata;
        hold_pc_q    <= addr_q;
      end

      if (deliver) begin
        if_q.valid <= 1'b1;
        if_q.instr <= fetch_data;
        if_q.pc    <= fetch_pc;
      end else if (in_redir) begin
        if_q.valid <= 1'b0;
        if_q.instr <= NOP_INSTR;
      end
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = ((state_q == REQ) && fresh_q) ? pc_cur : addr_q;
  assign redir_tgt = redir_tgt_q;
  assign if_valid  = if_q.valid;
  assign if_instr  = if_q.instr;
  assign if_pc     = if_q.pc;

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Instruction-fetch sequencer that drives the PC register's stall input and owns the IF-stage output buffer.
- Issues one instruction read at a time over a req/gnt/rvalid memory port, which the AXI master wrapper converts to AR/R beats.
- Merges instruction-side wait, data-side busy and post-reset boot hold into the PC stall and the global pipeline stall.
- Sequences branch/jump redirects, including discarding a response that is still in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC value the core boots from; if_pc reset value
NOP_INSTR, 32'h0000_0013, instruction placed in the IF buffer on reset and on flush
BOOT_CYCLES, 1, cycles the PC and fetch are held after reset release (range 1..15)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
pc_cur  in  32  current PC from the PC register
hazard_hold  in  1  load-use hold from the hazard unit; blocks delivery of a new instruction
dmem_busy  in  1  LSU transaction outstanding
redirect  in  1  taken branch/jump from EX, single-cycle pulse
redirect_pc  in  32  redirect target, valid with redirect
pc_stall  out  1  drives the PC register's CPU_stall input; 0 lets the PC load Next_PC
next_pc_sel  out  1  1 = the PC Next_PC mux selects redir_tgt
redir_tgt  out  32  latched redirect target
cpu_stall  out  1  global stall for the pipeline registers
imem_req  out  1  read request
imem_addr  out  32  read address
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  32  read data
if_valid  out  1  IF/ID instruction valid
if_instr  out  32  IF/ID instruction
if_pc  out  32  PC of if_instr

Behaviour:
- Reset values (asynchronous, immediate):
  - State BOOT; boot counter = BOOT_CYCLES.
  - imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=NOP_INSTR, if_pc=RESET_PC.
  - redir_pend=0, redir_tgt=RESET_PC, next_pc_sel=0.
  - pc_stall=1, cpu_stall=1.
- Reset mid-transaction: imem_req drops immediately. Any response that arrives later is ignored because the state is BOOT.
- States: BOOT, REQ, WAIT, HOLD, KILL, REDIR.
  - BOOT: counter decrements each cycle; at 0 go to REQ. redirect is ignored.
  - REQ: imem_req=1, imem_addr=pc_cur sampled on entry. req and addr stay stable until imem_gnt; a request is never withdrawn. On gnt go to WAIT.
  - WAIT: wait for imem_rvalid.
  - HOLD: fetched instruction is buffered; wait for downstream to accept it.
  - KILL: discard the in-flight response; on imem_rvalid go to REDIR.
  - REDIR: lasts one cycle, then go to REQ.
- Derived signals:
  - have_instr = (WAIT & imem_rvalid) | HOLD.
  - cpu_stall = dmem_busy | ~have_instr, except in REDIR where cpu_stall = dmem_busy.
  - deliver = have_instr & ~dmem_busy & ~hazard_hold & ~redirect & ~redir_pend.
- Deliver cycle:
  - pc_stall=0 with next_pc_sel=0, so the PC advances at this edge.
  - At the same edge: if_instr <= data (rdata, or the HOLD buffer), if_pc <= fetch address, if_valid <= 1.
  - Next state REQ; the next request is issued the following cycle using the new pc_cur.
  - Fetch-to-fetch minimum is 3 cycles with 1-cycle gnt and 1-cycle rvalid.
- WAIT with imem_rvalid but not deliver: capture rdata and address into the HOLD buffer; pc_stall stays 1.
- hazard_hold with an instruction available: cpu_stall=0, so downstream advances and inserts a bubble, while IF/ID and the PC hold.
- Redirect (accepted in any state except BOOT):
  - redir_tgt <= redirect_pc and redir_pend <= 1. A newer redirect overwrites the target.
  - From REQ without gnt: stay in REQ until gnt, then go to KILL.
  - From REQ with gnt in the same cycle: go to KILL.
  - From WAIT without rvalid: go to KILL.
  - From WAIT with rvalid in the same cycle: data is discarded; go to REDIR.
  - From HOLD: buffer is dropped; go to REDIR.
- REDIR cycle:
  - pc_stall=0, next_pc_sel=1, so the PC loads redir_tgt.
  - if_valid <= 0 and if_instr <= NOP_INSTR.
  - redir_pend <= 0.
- pc_stall is 1 in every cycle other than a deliver cycle or a REDIR cycle.

Decomposition:
- Package pc_fetch_pkg: fetch_state_e enum, NOP_INSTR and RESET_PC defaults, and an if_pkt_t struct {pc, instr, valid} shared with the IF/ID register.
- Single module; no sub-module is needed. The HOLD buffer is inline registers.

Test Plan:
1. Reset release, BOOT_CYCLES=1 -> imem_req first asserts 2 cycles after rst falls, imem_addr=0; pc_stall=1 throughout.
2. gnt after 3 cycles, rvalid 1 cycle later with rdata=32'h00500093 -> imem_addr held stable for 3 cycles; pc_stall=0 for exactly one cycle; if_instr=32'h00500093, if_pc=0, if_valid=1.
3. rvalid arrives while dmem_busy=1 for 4 cycles -> state HOLD, pc_stall=1 and cpu_stall=1 for those 4 cycles; instruction is delivered in the first cycle after dmem_busy falls.
4. redirect to 32'h100 while in WAIT; stale rvalid arrives 2 cycles later with rdata=32'hDEADBEEF -> 0xDEADBEEF never reaches if_instr; REDIR cycle with next_pc_sel=1 and redir_tgt=32'h100; if_valid=0; next imem_addr=32'h100.
5. redirect in the same cycle as rvalid -> data discarded, REDIR entered the next cycle, no KILL state.
6. rst asserted in WAIT -> imem_req=0 and outputs at reset values immediately; a late rvalid is ignored and no if_valid pulse occurs.
